lpc_io_target: RTL and testbench



---
 rtl/lpc_io_target_if.sv | 26 ++
 rtl/lpc_io_target.sv | 161 ++++++++++++++++
 tb/tb_lpc_io_target.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lpc_io_target_if.sv
// LPC pin bundle plus the register-side valid/ready request channel.
interface lpc_io_target_if;
  logic       lpc_frame;
  logic [3:0] lpc_ad_in;
  logic [3:0] lpc_ad_out;
  logic       lpc_ad_oe;
  logic       req_valid;
  logic       req_write;
  logic       req_dev;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic [7:0] rsp_rdata;

  // Target side: samples the LPC pads, drives LAD and the register request.
  modport slave (
    input  lpc_frame, lpc_ad_in, req_ready, rsp_rdata,
    output lpc_ad_out, lpc_ad_oe, req_valid, req_write, req_dev, req_addr, req_wdata
  );

  // Host/device side: drives the pads and answers register requests.
  modport master (
    output lpc_frame, lpc_ad_in, req_ready, rsp_rdata,
    input  lpc_ad_out, lpc_ad_oe, req_valid, req_write, req_dev, req_addr, req_wdata
  );
endinterface

// File: rtl/lpc_io_target.sv
// LPC I/O cycle target: decodes UART/POST windows, issues one register
// request per cycle, drives SYNC (long wait / error) and read data on LAD.
module lpc_io_target #(
  parameter logic [15:0] UART_BASE = 16'h03F8,
  parameter logic [15:0] POST_PORT = 16'h0080,
  parameter int          WAIT_MAX  = 64
) (
  input logic             lpc_clk,
  input logic             lpc_rst,
  lpc_io_target_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, CTDIR, ADDR, WDATA0, WDATA1, TAR1, TAR2,
    SYNC, RDATA0, RDATA1, PTAR1, PTAR2, SKIP
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t      state, nxt;
  logic        is_wr;
  logic [1:0]  nib_cnt;
  logic [15:0] addr_sr;
  logic        acked;
  logic [7:0]  wait_cnt;
  logic [7:0]  rdata;
  logic [3:0]  ad_out;
  logic        ad_oe;

  // Address as it stands once the current (last) nibble is shifted in.
  logic [15:0] full_addr;
  logic        uart_hit, post_hit, hit, accept, timeout;

  assign full_addr = {addr_sr[11:0], bus.lpc_ad_in};
  assign uart_hit  = (full_addr[15:3] == UART_BASE[15:3]);
  assign post_hit  = (full_addr == POST_PORT);
  assign hit       = uart_hit | post_hit;
  assign accept    = bus.req_valid & bus.req_ready;
  assign timeout   = (wait_cnt == WAIT_LIM);

  // State register.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) state <= IDLE;
    else          state <= nxt;
  end

  // Next state; LFRAME# low overrides everything (START or abort).
  always_comb begin
    nxt = state;
    if (!bus.lpc_frame) begin
      nxt = (bus.lpc_ad_in == 4'h0) ? CTDIR : SKIP;
    end else begin
      unique case (state)
        IDLE:   nxt = IDLE;
        CTDIR:  nxt = (bus.lpc_ad_in == 4'h0 || bus.lpc_ad_in == 4'h2) ? ADDR : SKIP;
        ADDR:   if (nib_cnt == 2'd3) nxt = !hit ? SKIP : (is_wr ? WDATA0 : TAR1);
        WDATA0: nxt = WDATA1;
        WDATA1: nxt = TAR1;
        TAR1:   nxt = TAR2;
        TAR2:   nxt = SYNC;
        SYNC:   if (acked)        nxt = is_wr ? PTAR1 : RDATA0;
                else if (timeout) nxt = PTAR1;
        RDATA0: nxt = RDATA1;
        RDATA1: nxt = PTAR1;
        PTAR1:  nxt = PTAR2;
        PTAR2:  nxt = IDLE;
        SKIP:   nxt = SKIP;
        default: nxt = IDLE;
      endcase
    end
  end

  // LAD drive; released combinationally as soon as LFRAME# drops.
  always_comb begin
    ad_oe  = 1'b0;
    ad_out = 4'h0;
    if (bus.lpc_frame) begin
      unique case (state)
        SYNC: begin
          ad_oe  = 1'b1;
          ad_out = acked ? 4'h0 : (timeout ? 4'hA : 4'h6);
        end
        RDATA0: begin ad_oe = 1'b1; ad_out = rdata[3:0]; end
        RDATA1: begin ad_oe = 1'b1; ad_out = rdata[7:4]; end
        PTAR1:  begin ad_oe = 1'b1; ad_out = 4'hF;       end
        default: ;
      endcase
    end
  end

  assign bus.lpc_ad_oe  = ad_oe;
  assign bus.lpc_ad_out = ad_out;

  // Cycle datapath: address/data capture, request handshake, wait counter.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      is_wr         <= 1'b0;
      nib_cnt       <= 2'd0;
      addr_sr       <= 16'h0;
      acked         <= 1'b0;
      wait_cnt      <= 8'h0;
      rdata         <= 8'h0;
      bus.req_valid <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_dev   <= 1'b0;
      bus.req_addr  <= 3'd0;
      bus.req_wdata <= 8'h0;
    end else if (!bus.lpc_frame) begin
      // Abort or new START: any outstanding request is abandoned; an accept
      // landing in this cycle is ignored here.
      bus.req_valid <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_dev   <= 1'b0;
      bus.req_addr  <= 3'd0;
      bus.req_wdata <= 8'h0;
      acked         <= 1'b0;
    end else begin
      unique case (state)
        CTDIR: begin
          is_wr   <= (bus.lpc_ad_in == 4'h2);
          nib_cnt <= 2'd0;
        end
        ADDR: begin
          addr_sr <= full_addr;
          nib_cnt <= nib_cnt + 2'd1;
          if (nib_cnt == 2'd3 && hit) begin
            bus.req_write <= is_wr;
            bus.req_dev   <= post_hit;
            bus.req_addr  <= post_hit ? 3'd0 : full_addr[2:0];
            bus.req_wdata <= 8'h0;
            if (!is_wr) begin
              bus.req_valid <= 1'b1;
              acked         <= 1'b0;
              wait_cnt      <= 8'h0;
            end
          end
        end
        WDATA0: bus.req_wdata[3:0] <= bus.lpc_ad_in;
        WDATA1: begin
          bus.req_wdata[7:4] <= bus.lpc_ad_in;
          bus.req_valid      <= 1'b1;
          acked              <= 1'b0;
          wait_cnt           <= 8'h0;
        end
        SYNC: begin
          if (!acked) begin
            if (timeout) bus.req_valid <= 1'b0;
            else         wait_cnt      <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
      if (accept) begin
        bus.req_valid <= 1'b0;
        acked         <= 1'b1;
        rdata         <= bus.rsp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lpc_io_target.sv
// Scoreboard bench: stimulus pushes expected LAD nibbles (with cycle stamps)
// and expected register requests; a negedge monitor pops and compares.
module tb_lpc_io_target;

  logic lpc_clk = 1'b0;
  logic lpc_rst = 1'b0;
  always #5 lpc_clk = ~lpc_clk;

  lpc_io_target_if bus ();

  lpc_io_target #(
    .UART_BASE(16'h03F8),
    .POST_PORT(16'h0080),
    .WAIT_MAX (4)
  ) dut (
    .lpc_clk(lpc_clk),
    .lpc_rst(lpc_rst),
    .bus    (bus.slave)
  );

  typedef struct { int cyc; logic [3:0] nib; } lad_t;
  typedef struct { logic wr; logic dev; logic [2:0] addr; logic [7:0] wdata; } req_t;

  lad_t lad_q[$];
  req_t req_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0;
  int vld_cnt = 0;
  int oe_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_lad(input int c, input logic [3:0] n);
    lad_t e;
    e.cyc = c; e.nib = n;
    lad_q.push_back(e);
  endtask

  task automatic push_req(input logic wr, input logic dev, input logic [2:0] a, input logic [7:0] wd);
    req_t e;
    e.wr = wr; e.dev = dev; e.addr = a; e.wdata = wd;
    req_q.push_back(e);
  endtask

  // Monitor: every driven LAD nibble and every accepted request is checked.
  always @(negedge lpc_clk) begin
    lad_t le;
    req_t re;
    ncyc = ncyc + 1;
    if (bus.req_valid) vld_cnt = vld_cnt + 1;
    if (bus.lpc_ad_oe) begin
      oe_cnt = oe_cnt + 1;
      if (lad_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL lad_unexpected: got nibble %0h at cycle %0d, required no drive", bus.lpc_ad_out, ncyc);
      end else begin
        le = lad_q.pop_front();
        chk("lad_cycle", ncyc, le.cyc);
        chk("lad_nibble", {28'h0, bus.lpc_ad_out}, {28'h0, le.nib});
      end
    end
    if (bus.req_valid && bus.req_ready) begin
      if (req_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL req_unexpected: accept at cycle %0d, required none", ncyc);
      end else begin
        re = req_q.pop_front();
        chk("req_write", {31'h0, bus.req_write}, {31'h0, re.wr});
        chk("req_dev",   {31'h0, bus.req_dev},   {31'h0, re.dev});
        chk("req_addr",  {29'h0, bus.req_addr},  {29'h0, re.addr});
        chk("req_wdata", {24'h0, bus.req_wdata}, {24'h0, re.wdata});
      end
    end
  end

  // One bus cycle: drive pads/ready, then wait past the next rising edge.
  task automatic tick(input logic f, input logic [3:0] d, input logic rdy);
    bus.lpc_frame = f;
    bus.lpc_ad_in = d;
    bus.req_ready = rdy;
    @(posedge lpc_clk);
    #1;
  endtask

  // Host cycle of n clocks from START; ready high from rdy_at, LFRAME# pulse at abort_at.
  task automatic xfer(input logic [3:0] dir, input logic [15:0] a, input logic [7:0] wd,
                      input int rdy_at, input int abort_at, input int n);
    for (int k = 0; k < n; k++) begin
      logic       f;
      logic [3:0] d;
      f = 1'b1; d = 4'hF;
      if (k == abort_at)                   begin f = 1'b0; d = 4'hF; end
      else if (k == 0)                     begin f = 1'b0; d = 4'h0; end
      else if (k == 1)                     d = dir;
      else if (k >= 2 && k <= 5)           d = a[(5-k)*4 +: 4];
      else if (dir == 4'h2 && k == 6)      d = wd[3:0];
      else if (dir == 4'h2 && k == 7)      d = wd[7:4];
      tick(f, d, k >= rdy_at);
    end
    bus.lpc_frame = 1'b1;
    bus.lpc_ad_in = 4'hF;
    bus.req_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe"},     {31'h0, bus.lpc_ad_oe},  32'h0);
    chk({tag, "_ad_out"}, {28'h0, bus.lpc_ad_out}, 32'h0);
    chk({tag, "_valid"},  {31'h0, bus.req_valid},  32'h0);
    chk({tag, "_write"},  {31'h0, bus.req_write},  32'h0);
    chk({tag, "_dev"},    {31'h0, bus.req_dev},    32'h0);
    chk({tag, "_addr"},   {29'h0, bus.req_addr},   32'h0);
    chk({tag, "_wdata"},  {24'h0, bus.req_wdata},  32'h0);
  endtask

  initial begin
    int b, v0, o0;
    bus.lpc_frame = 1'b1;
    bus.lpc_ad_in = 4'hF;
    bus.req_ready = 1'b0;
    bus.rsp_rdata = 8'h00;
    repeat (3) @(posedge lpc_clk);
    #1;
    chk_reset_outputs("reset");
    lpc_rst = 1'b1;
    tick(1'b1, 4'hF, 1'b0);

    // Read 0x03FD, ready tied high, data 0x61.
    bus.rsp_rdata = 8'h61;
    b = ncyc + 1;
    push_req(1'b0, 1'b0, 3'd5, 8'h00);
    push_lad(b + 8, 4'h0); push_lad(b + 9, 4'h1); push_lad(b + 10, 4'h6); push_lad(b + 11, 4'hF);
    xfer(4'h0, 16'h03FD, 8'h00, 0, -1, 14);

    // Write 0x0080 <- 0x55, ready tied high.
    b = ncyc + 1; v0 = vld_cnt;
    push_req(1'b1, 1'b1, 3'd0, 8'h55);
    push_lad(b + 10, 4'h0); push_lad(b + 11, 4'hF);
    xfer(4'h2, 16'h0080, 8'h55, 0, -1, 14);
    chk("post_wr_valid_cycles", vld_cnt - v0, 1);

    // Write 0x03F8 <- 0xA5, ready low through cycle 11, accepted in cycle 12.
    b = ncyc + 1; v0 = vld_cnt;
    push_req(1'b1, 1'b0, 3'd0, 8'hA5);
    push_lad(b + 10, 4'h6); push_lad(b + 11, 4'h6); push_lad(b + 12, 4'h6);
    push_lad(b + 13, 4'h0); push_lad(b + 14, 4'hF);
    xfer(4'h2, 16'h03F8, 8'hA5, 12, -1, 17);
    chk("wait_wr_valid_cycles", vld_cnt - v0, 5);

    // Read 0x03F8, never ready: four long waits, error SYNC, PTAR.
    b = ncyc + 1; v0 = vld_cnt;
    push_lad(b + 8, 4'h6); push_lad(b + 9, 4'h6); push_lad(b + 10, 4'h6); push_lad(b + 11, 4'h6);
    push_lad(b + 12, 4'hA); push_lad(b + 13, 4'hF);
    xfer(4'h0, 16'h03F8, 8'h00, 1000, -1, 16);
    chk("timeout_valid_cycles", vld_cnt - v0, 7);
    chk("timeout_valid_low", {31'h0, bus.req_valid}, 32'h0);

    // Address miss and memory-read cycle type: no drive, no request.
    v0 = vld_cnt; o0 = oe_cnt;
    xfer(4'h0, 16'h0060, 8'h00, 0, -1, 14);
    xfer(4'h4, 16'h03F8, 8'h00, 0, -1, 14);
    chk("skip_valid_cycles", vld_cnt - v0, 0);
    chk("skip_oe_cycles", oe_cnt - o0, 0);

    // A valid START after SKIP decodes normally: read 0x03F9 -> 0xC3.
    bus.rsp_rdata = 8'hC3;
    b = ncyc + 1;
    push_req(1'b0, 1'b0, 3'd1, 8'h00);
    push_lad(b + 8, 4'h0); push_lad(b + 9, 4'h3); push_lad(b + 10, 4'hC); push_lad(b + 11, 4'hF);
    xfer(4'h0, 16'h03F9, 8'h00, 0, -1, 14);

    // LFRAME# pulse in cycle 9 of a pending read.
    b = ncyc + 1; v0 = vld_cnt; o0 = oe_cnt;
    push_lad(b + 8, 4'h6);
    xfer(4'h0, 16'h03F8, 8'h00, 1000, 9, 13);
    chk("abort_oe_cycles", oe_cnt - o0, 1);
    chk("abort_valid_cycles", vld_cnt - v0, 4);
    chk_reset_outputs("abort");

    // Reset asserted in the middle of SYNC of a pending read.
    b = ncyc + 1;
    push_lad(b + 8, 4'h6);
    xfer(4'h0, 16'h03F8, 8'h00, 1000, -1, 9);
    lpc_rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge lpc_clk);
    #1;
    lpc_rst = 1'b1;
    tick(1'b1, 4'hF, 1'b0);

    // Back-to-back: read 0x03FA -> 0x7E, START right after PTAR2, then write.
    bus.rsp_rdata = 8'h7E;
    b = ncyc + 1;
    push_req(1'b0, 1'b0, 3'd2, 8'h00);
    push_lad(b + 8, 4'h0); push_lad(b + 9, 4'hE); push_lad(b + 10, 4'h7); push_lad(b + 11, 4'hF);
    push_req(1'b1, 1'b1, 3'd0, 8'h3C);
    push_lad(b + 13 + 10, 4'h0); push_lad(b + 13 + 11, 4'hF);
    xfer(4'h0, 16'h03FA, 8'h00, 0, -1, 13);
    xfer(4'h2, 16'h0080, 8'h3C, 0, -1, 14);

    repeat (3) tick(1'b1, 4'hF, 1'b0);
    chk("lad_queue_drained", lad_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
